note_recorder: RTL and testbench

NOTE_RECORDER -- requirements
Module: note_recorder

---
 rtl/note_recorder.sv | 272 +++++++++++++++++++++++++++
 tb/tb_note_recorder.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_recorder.sv
// -----------------------------------------------------------------------------
// note_recorder
//
// Records and replays the note-switch bus of a simple piano. In IDLE and
// RECORD the synchronized switches pass straight through to sw_out. In RECORD
// every change of the switch value closes the current event and stores
// {note, duration in ticks}. Silence (0x00) is stored like any other note.
// In PLAY the stored events drive sw_out, each for its recorded duration.
//
// Parameters
//   DEPTH    : maximum stored events (power of two, 2..256)
//   TICK_DIV : CLK cycles per duration tick
//   DUR_W    : width of a stored duration; longer notes are split into
//              several entries of 2^DUR_W-1 ticks
//
// Ports
//   CLK      : system clock, all state on the rising edge
//   RESET    : asynchronous, active-high reset
//   sw_in    : raw note switches (bit 7 = C4 ... bit 0 = C5), asynchronous
//   btn_rec  : raw record button level, asynchronous
//   btn_play : raw play button level, asynchronous
//   sw_out   : registered note bus towards the piano
//   mode     : 00 IDLE, 01 RECORD, 10 PLAY
//   count    : number of stored events
//   full     : last recording stopped because the buffer filled up
//
// Configuration
//   NOTE_RECORDER_LOOP_EN : when defined, PLAY wraps from the last entry back
//                           to entry 0 until a play press or RESET; otherwise
//                           PLAY is one-shot.
// -----------------------------------------------------------------------------
module note_recorder #(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 1000000,
  parameter int DUR_W    = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [7:0]             sw_in,
  input  logic                   btn_rec,
  input  logic                   btn_play,
  output logic [7:0]             sw_out,
  output logic [1:0]             mode,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] DUR_MAX    = '1;
  localparam logic [CW-1:0]    DEPTH_C    = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RECORD = 2'b01,
    S_PLAY   = 2'b10
  } state_t;

  typedef struct packed {
    logic [7:0]       note;
    logic [DUR_W-1:0] dur;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers and button edge detectors
  // ---------------------------------------------------------------------------
  logic [7:0] sw_meta;
  logic [7:0] sw_sync;
  logic [1:0] btn_meta;   // [1] = rec, [0] = play
  logic [1:0] btn_sync;
  logic [1:0] btn_prev;
  logic       rec_edge;
  logic       play_edge;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the values from before the clock edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= '0;
      btn_sync <= '0;
      btn_prev <= '0;
    end else begin
      sw_meta  <= sw_in;
      sw_sync  <= sw_meta;
      btn_meta <= {btn_rec, btn_play};
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
    end
  end

  // Edges are taken from the second synchronizer stage, so a press arrives
  // in the same cycle as a switch change made at the same moment.
  assign rec_edge  = btn_sync[1] & ~btn_prev[1];
  assign play_edge = btn_sync[0] & ~btn_prev[0];

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t           state,    state_nx;
  logic [PW-1:0]    presc,    presc_nx;
  logic [DUR_W-1:0] elapsed,  elapsed_nx;
  logic [AW-1:0]    idx,      idx_nx;
  logic [CW-1:0]    cnt,      cnt_nx;
  logic             full_q,   full_nx;
  logic [7:0]       cur_note, cur_note_nx;
  logic [7:0]       sw_out_q, sw_out_nx;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= S_IDLE;
      presc    <= '0;
      elapsed  <= '0;
      idx      <= '0;
      cnt      <= '0;
      full_q   <= 1'b0;
      cur_note <= '0;
      sw_out_q <= '0;
    end else begin
      state    <= state_nx;
      presc    <= presc_nx;
      elapsed  <= elapsed_nx;
      idx      <= idx_nx;
      cnt      <= cnt_nx;
      full_q   <= full_nx;
      cur_note <= cur_note_nx;
      sw_out_q <= sw_out_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Event buffer
  // ---------------------------------------------------------------------------
  entry_t        mem [DEPTH];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  entry_t        wr_data;

  // NOTE: the event buffer has no reset; entries at or above count are never
  // read, so their power-up contents cannot reach sw_out.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Shared timing terms
  // ---------------------------------------------------------------------------
  logic             tick;
  logic [PW-1:0]    presc_inc;
  logic [DUR_W:0]   ticks_now;   // ticks of the current event, this cycle included
  logic [DUR_W-1:0] dur_store;
  logic [CW-1:0]    cnt_inc;
  logic [AW-1:0]    idx_inc;
  logic             last_entry;
  logic             change;
  logic             split;

  assign tick      = (presc == PRESC_LAST);
  assign presc_inc = tick ? '0 : presc + PW'(1);
  assign ticks_now = {1'b0, elapsed} + {{DUR_W{1'b0}}, tick};
  // An event shorter than one tick still lasts one tick on replay.
  assign dur_store = (ticks_now == '0) ? DUR_W'(1) : ticks_now[DUR_W-1:0];
  assign cnt_inc   = cnt + CW'(1);
  assign idx_inc   = idx + AW'(1);
  assign last_entry = ({1'b0, idx} == (cnt - CW'(1)));
  assign change    = (sw_sync != cur_note);
  assign split     = (ticks_now == {1'b0, DUR_MAX});

  // ---------------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value held (which would infer a latch).
  always_comb begin
    state_nx    = state;
    presc_nx    = presc_inc;
    elapsed_nx  = elapsed;
    idx_nx      = idx;
    cnt_nx      = cnt;
    full_nx     = full_q;
    cur_note_nx = cur_note;
    sw_out_nx   = sw_sync;
    wr_en       = 1'b0;
    wr_addr     = cnt[AW-1:0];
    wr_data     = '{note: cur_note, dur: dur_store};

    case (state)
      S_IDLE: begin
        if (rec_edge) begin
          // New take: forget the old one and start timing the present value.
          state_nx    = S_RECORD;
          cnt_nx      = '0;
          full_nx     = 1'b0;
          cur_note_nx = sw_sync;
          presc_nx    = '0;
          elapsed_nx  = '0;
        end else if (play_edge && (cnt != '0)) begin
          state_nx   = S_PLAY;
          idx_nx     = '0;
          presc_nx   = '0;
          elapsed_nx = '0;
          sw_out_nx  = mem[0].note;
        end
      end

      S_RECORD: begin
        if (tick) begin
          elapsed_nx = ticks_now[DUR_W-1:0];
        end
        // A change, a stop press or a duration at its ceiling all close the
        // in-progress event; for a split the "new" note is the same note.
        if (rec_edge || change || split) begin
          wr_en       = 1'b1;
          cnt_nx      = cnt_inc;
          cur_note_nx = sw_sync;
          presc_nx    = '0;
          elapsed_nx  = '0;
          if (rec_edge) begin
            state_nx = S_IDLE;
          end
          if (cnt_inc == DEPTH_C) begin
            full_nx  = 1'b1;
            state_nx = S_IDLE;
          end
        end
      end

      S_PLAY: begin
        sw_out_nx = sw_out_q;
        if (play_edge) begin
          state_nx = S_IDLE;
          sw_out_nx = sw_sync;
        end else if (tick) begin
          if (ticks_now == {1'b0, mem[idx].dur}) begin
            // Entry expired; the prescaler has just wrapped to 0 on its own.
            elapsed_nx = '0;
            if (last_entry) begin
`ifdef NOTE_RECORDER_LOOP_EN
              idx_nx    = '0;
              sw_out_nx = mem[0].note;
`else
              state_nx  = S_IDLE;
              sw_out_nx = sw_sync;
`endif
            end else begin
              idx_nx    = idx_inc;
              sw_out_nx = mem[idx_inc].note;
            end
          end else begin
            elapsed_nx = ticks_now[DUR_W-1:0];
          end
        end
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign sw_out = sw_out_q;
  assign mode   = state;
  assign count  = cnt;
  assign full   = full_q;

endmodule

// File: tb/tb_note_recorder.sv
// -----------------------------------------------------------------------------
// tb_note_recorder
//
// Self-checking bench for note_recorder with DEPTH=4, TICK_DIV=4, DUR_W=4.
// Recording stimulus is described as {note, hold cycles} segments; a small
// model turns them into the expected buffer contents. Each play press pushes
// those entries onto a scoreboard queue that is popped and compared against
// sw_out cycle by cycle while the DUT plays back.
// -----------------------------------------------------------------------------
module tb_note_recorder;

  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 4;
  localparam int DUR_W    = 4;
  localparam int DUR_MAX  = (1 << DUR_W) - 1;

  localparam logic [1:0] M_IDLE = 2'b00;
  localparam logic [1:0] M_REC  = 2'b01;
  localparam logic [1:0] M_PLAY = 2'b10;

  localparam logic [7:0] PT_NOTE = 8'h42;  // held on sw_in while playing

`ifdef NOTE_RECORDER_LOOP_EN
  localparam int LOOPS = 3;
`else
  localparam int LOOPS = 1;
`endif

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] sw_in;
  logic       btn_rec;
  logic       btn_play;
  logic [7:0] sw_out;
  logic [1:0] mode;
  logic [2:0] count;
  logic       full;

  note_recorder #(
    .DEPTH    (DEPTH),
    .TICK_DIV (TICK_DIV),
    .DUR_W    (DUR_W)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .sw_in    (sw_in),
    .btn_rec  (btn_rec),
    .btn_play (btn_play),
    .sw_out   (sw_out),
    .mode     (mode),
    .count    (count),
    .full     (full)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] note;
    int         hold;     // cycles until the next stimulus change
  } seg_t;

  typedef struct {
    logic [7:0] note;
    int         dur;      // ticks
  } entry_t;

  typedef struct {
    logic [7:0] sw;
    logic [7:0] exp_sw_out;
    logic [1:0] exp_mode;
  } pt_vec_t;

  int     n_vec = 0;
  int     n_err = 0;
  seg_t   segs[$];
  entry_t model_mem[$];
  entry_t sb[$];
  int     model_cnt;
  bit     model_full;
  bit     model_rec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns so outputs are sampled and
  // inputs are driven away from the edge.
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic add_seg(input logic [7:0] note, input int hold);
    seg_t s;
    s.note = note;
    s.hold = hold;
    segs.push_back(s);
  endtask

  task automatic push_entry(input logic [7:0] note, input int dur);
    entry_t e;
    e.note = note;
    e.dur  = dur;
    model_mem.push_back(e);
    model_cnt++;
  endtask

  // Expected entries for a segment that has just ended.
  task automatic close_entry(input seg_t s);
    int t;
    t = s.hold / TICK_DIV;
    while (t > DUR_MAX && model_cnt < DEPTH) begin
      push_entry(s.note, DUR_MAX);
      t -= DUR_MAX;
    end
    if (model_cnt < DEPTH) push_entry(s.note, (t == 0) ? 1 : t);
    if (model_cnt == DEPTH) begin
      model_full = 1'b1;
      model_rec  = 1'b0;
    end
  endtask

  // Press rec together with the first segment, walk through all segments,
  // optionally press rec again to stop. Holds must be at least 3 cycles.
  task automatic do_record(input bit end_rec);
    model_mem.delete();
    model_cnt  = 0;
    model_full = 1'b0;
    model_rec  = 1'b1;
    foreach (segs[k]) begin
      if (k == 0) btn_rec = 1'b1;
      else if (model_rec) close_entry(segs[k-1]);
      sw_in = segs[k].note;
      step(1);
      btn_rec = 1'b0;
      step(2);
      check($sformatf("rec_mode_seg%0d", k), mode, model_rec ? M_REC : M_IDLE);
      check($sformatf("rec_count_seg%0d", k), count, model_cnt);
      step(segs[k].hold - 3);
    end
    if (end_rec && model_rec) begin
      btn_rec = 1'b1;
      close_entry(segs[segs.size()-1]);
      model_rec = 1'b0;
      step(1);
      btn_rec = 1'b0;
      step(2);
      check("rec_stop_mode", mode, M_IDLE);
    end
    check("rec_final_count", count, model_cnt);
    check("rec_final_full", full, model_full);
  endtask

  // Play the model contents `loops` times and compare every cycle.
  task automatic do_play(input int loops);
    entry_t e;
    int     bad;
    sb.delete();
    repeat (loops) foreach (model_mem[i]) sb.push_back(model_mem[i]);
    sw_in    = PT_NOTE;
    btn_play = 1'b1;
    step(1);
    btn_play = 1'b0;
    step(2);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      bad = 0;
      repeat (e.dur * TICK_DIV) begin
        if (sw_out !== e.note || mode !== M_PLAY) bad++;
        step(1);
      end
      check($sformatf("play_%02h_d%0d_bad_cycles", e.note, e.dur), bad, 0);
    end
`ifdef NOTE_RECORDER_LOOP_EN
    btn_play = 1'b1;
    step(1);
    btn_play = 1'b0;
    step(2);
`endif
    check("play_end_mode", mode, M_IDLE);
    check("play_end_sw_out", sw_out, PT_NOTE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pt_vec_t    pt[6];
    logic [7:0] prev_exp;
    int         bad;

    pt[0] = '{8'hFF, 8'hFF, M_IDLE};
    pt[1] = '{8'h00, 8'h00, M_IDLE};
    pt[2] = '{8'h55, 8'h55, M_IDLE};
    pt[3] = '{8'hAA, 8'hAA, M_IDLE};
    pt[4] = '{8'h01, 8'h01, M_IDLE};
    pt[5] = '{8'h80, 8'h80, M_IDLE};

    // ---- reset with 0x80 on the switches ----
    RESET    = 1'b1;
    sw_in    = 8'h80;
    btn_rec  = 1'b0;
    btn_play = 1'b0;
    step(3);
    check("reset_sw_out", sw_out, 8'h00);
    check("reset_mode", mode, M_IDLE);
    check("reset_count", count, 0);
    check("reset_full", full, 0);
    RESET = 1'b0;
    step(2);
    check("post_reset_sw_out_early", sw_out, 8'h00);
    step(1);
    check("post_reset_sw_out", sw_out, 8'h80);
    check("post_reset_mode", mode, M_IDLE);
    prev_exp = 8'h80;

    // ---- passthrough table, exactly 3 cycles of latency ----
    for (int i = 0; i < 6; i++) begin
      sw_in = pt[i].sw;
      step(2);
      check($sformatf("pt%0d_hold", i), sw_out, prev_exp);
      step(1);
      check($sformatf("pt%0d_sw_out", i), sw_out, pt[i].exp_sw_out);
      check($sformatf("pt%0d_mode", i), mode, pt[i].exp_mode);
      prev_exp = pt[i].exp_sw_out;
    end

    // ---- two notes, then playback ----
    segs.delete();
    add_seg(8'h80, 12);
    add_seg(8'h20, 8);
    do_record(1'b1);
    do_play(LOOPS);

    // ---- abort in the middle of entry 1 ----
    sw_in    = PT_NOTE;
    btn_play = 1'b1;
    step(1);
    btn_play = 1'b0;
    step(2);
    bad = 0;
    repeat (model_mem[0].dur * TICK_DIV) begin
      if (sw_out !== model_mem[0].note || mode !== M_PLAY) bad++;
      step(1);
    end
    check("abort_entry0_bad_cycles", bad, 0);
    bad = 0;
    repeat (2) begin
      if (sw_out !== model_mem[1].note || mode !== M_PLAY) bad++;
      step(1);
    end
    check("abort_entry1_bad_cycles", bad, 0);
    btn_play = 1'b1;
    step(1);
    check("abort_latency1_mode", mode, M_PLAY);
    btn_play = 1'b0;
    step(1);
    check("abort_latency2_mode", mode, M_PLAY);
    step(1);
    check("abort_mode", mode, M_IDLE);
    check("abort_sw_out", sw_out, PT_NOTE);
    check("abort_count_kept", count, 2);

    // ---- contents survive IDLE and an aborted PLAY ----
    do_play(LOOPS);

    // ---- long note split at the duration ceiling ----
    segs.delete();
    add_seg(8'h10, 80);
    do_record(1'b1);
    do_play(LOOPS);

    // ---- silence as an event, sub-tick event clamped to 1 ----
    segs.delete();
    add_seg(8'h00, 8);
    add_seg(8'h33, 3);
    add_seg(8'h00, 4);
    do_record(1'b1);
    do_play(LOOPS);

    // ---- buffer full on the 4th write, 5th change ignored ----
    segs.delete();
    add_seg(8'h01, 4);
    add_seg(8'h02, 4);
    add_seg(8'h04, 4);
    add_seg(8'h08, 4);
    add_seg(8'h10, 4);
    add_seg(8'h20, 4);
    do_record(1'b0);
    check("full_mode_idle", mode, M_IDLE);
    do_play(LOOPS);
    check("full_kept_after_play", full, 1);

    // ---- rec and play pressed together: rec wins, full cleared ----
    btn_play = 1'b1;
    segs.delete();
    add_seg(8'h05, 8);
    do_record(1'b1);
    btn_play = 1'b0;
    step(2);
    check("rec_wins_mode", mode, M_IDLE);

    // ---- reset mid-PLAY, then play with an empty buffer is ignored ----
    sw_in    = PT_NOTE;
    btn_play = 1'b1;
    step(1);
    btn_play = 1'b0;
    step(3);
    check("midplay_mode", mode, M_PLAY);
    check("midplay_sw_out", sw_out, 8'h05);
    RESET = 1'b1;
    #1;
    check("midplay_reset_mode", mode, M_IDLE);
    check("midplay_reset_sw_out", sw_out, 8'h00);
    check("midplay_reset_count", count, 0);
    check("midplay_reset_full", full, 0);
    step(2);
    RESET = 1'b0;
    step(3);
    check("post_reset2_sw_out", sw_out, PT_NOTE);
    btn_play = 1'b1;
    step(1);
    btn_play = 1'b0;
    step(4);
    check("empty_play_mode", mode, M_IDLE);
    check("empty_play_sw_out", sw_out, PT_NOTE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
